// File: rtl/key_pkg.sv
// Shared types and width helpers for the multi-channel key front end.
package key_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_LONG    = 2'd2
    } key_st_t;

    // Bits needed to hold values 0..n inclusive, never less than 1.
    function automatic int cnt_w(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One key channel: 2-FF synchroniser, symmetric debounce, press/release/long tics.
// Auto-repeat in S_LONG is built only when KEY_AUTO_REPEAT_EN is defined.
//
//   state     | meaning
//   S_IDLE    | debounced key released, waiting for a press
//   S_PRESSED | key held, timing towards long_tic
//   S_LONG    | long_tic already issued; waits for release (or auto-repeats)
module key_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic key_state,
    output logic press_tic,
    output logic release_tic,
    output logic long_tic,
    output logic repeat_tic
);

    localparam int DW = cnt_w(DEBOUNCE_CYCLES);
    localparam int HW = cnt_w(max2(LONG_CYCLES, REPEAT_CYCLES));
    localparam logic [DW-1:0] DC_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] LC_LAST = HW'(LONG_CYCLES - 1);
`ifdef KEY_AUTO_REPEAT_EN
    localparam logic [HW-1:0] RC_LAST = HW'(REPEAT_CYCLES - 1);
`endif

    logic          sync1_q, sync1_d;
    logic          ks_q, ks_d;
    logic          key_state_q, key_state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    key_st_t       state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          rise, fall;
`ifdef KEY_AUTO_REPEAT_EN
    logic          repeat_q, repeat_d;
`endif

    // Debounce: the counter only runs while the synced level disagrees with key_state.
    always_comb begin
        sync1_d     = key;
        ks_d        = sync1_q;
        key_state_d = key_state_q;
        dcnt_d      = '0;
        rise        = 1'b0;
        fall        = 1'b0;
        if (ks_q != key_state_q) begin
            if (dcnt_q == DC_LAST) begin
                key_state_d = ks_q;
                rise        = ks_q;
                fall        = ~ks_q;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    // Release takes priority over any long/repeat tic falling on the same edge.
    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        press_d   = rise;
        release_d = fall;
        long_d    = 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
        repeat_d  = 1'b0;
`endif
        if (fall) begin
            state_d = S_IDLE;
            hcnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rise) begin
                        state_d = S_PRESSED;
                        hcnt_d  = '0;
                    end
                end
                S_PRESSED: begin
                    if (hcnt_q == LC_LAST) begin
                        long_d  = 1'b1;
                        state_d = S_LONG;
                        hcnt_d  = '0;
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                end
                S_LONG: begin
`ifdef KEY_AUTO_REPEAT_EN
                    if (hcnt_q == RC_LAST) begin
                        repeat_d = 1'b1;
                        hcnt_d   = '0;
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
`else
                    hcnt_d = '0;
`endif
                end
                default: begin
                    state_d = S_IDLE;
                    hcnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            ks_q        <= 1'b0;
            key_state_q <= 1'b0;
            dcnt_q      <= '0;
            state_q     <= S_IDLE;
            hcnt_q      <= '0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            ks_q        <= ks_d;
            key_state_q <= key_state_d;
            dcnt_q      <= dcnt_d;
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

`ifdef KEY_AUTO_REPEAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= repeat_d;
        end
    end
    assign repeat_tic = repeat_q;
`else
    assign repeat_tic = 1'b0;
`endif

    assign key_state   = key_state_q;
    assign press_tic   = press_q;
    assign release_tic = release_q;
    assign long_tic    = long_q;

endmodule

// File: rtl/multi_key_handler.sv
// N independent push-button channels, each a key_channel slice.
// Define KEY_AUTO_REPEAT_EN to enable auto-repeat tics while a key is held past long_tic.
module multi_key_handler
    import key_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] press_tic,
    output logic [N_KEYS-1:0] release_tic,
    output logic [N_KEYS-1:0] long_tic,
    output logic [N_KEYS-1:0] repeat_tic
);

    if (N_KEYS < 1) begin : g_bad_n_keys
        $error("multi_key_handler: N_KEYS must be >= 1");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("multi_key_handler: DEBOUNCE_CYCLES must be >= 1");
    end
    if (LONG_CYCLES < 1) begin : g_bad_long
        $error("multi_key_handler: LONG_CYCLES must be >= 1");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("multi_key_handler: REPEAT_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .key         (key[i]),
            .key_state   (key_state[i]),
            .press_tic   (press_tic[i]),
            .release_tic (release_tic[i]),
            .long_tic    (long_tic[i]),
            .repeat_tic  (repeat_tic[i])
        );
    end

endmodule

// File: tb/tb_multi_key_handler.sv
// Bench for multi_key_handler: directed vector table, hand sequences and a random run against a reference model.
module tb_multi_key_handler;

    localparam int NK = 4;
    localparam int DC = 4;
    localparam int LC = 20;
    localparam int RC = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] key = '0;
    logic [NK-1:0] key_state, press_tic, release_tic, long_tic, repeat_tic;

    multi_key_handler #(
        .N_KEYS          (NK),
        .DEBOUNCE_CYCLES (DC),
        .LONG_CYCLES     (LC),
        .REPEAT_CYCLES   (RC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key         (key),
        .key_state   (key_state),
        .press_tic   (press_tic),
        .release_tic (release_tic),
        .long_tic    (long_tic),
        .repeat_tic  (repeat_tic)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    // Reference model: raw key delayed two cycles, run length of disagreeing cycles,
    // and the number of cycles elapsed since the press was recognised.
    logic [NK-1:0] m_s1 = '0, m_s2 = '0, m_ks = '0;
    logic [NK-1:0] m_pr = '0, m_rl = '0, m_lg = '0, m_rp = '0;
    int run [NK];
    int age [NK];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic model_step();
        logic prev;
        logic toggled;
        m_pr = '0; m_rl = '0; m_lg = '0; m_rp = '0;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_ks = '0;
            for (int c = 0; c < NK; c++) begin
                run[c] = 0;
                age[c] = 0;
            end
        end else begin
            for (int c = 0; c < NK; c++) begin
                prev    = m_s2[c];
                m_s2[c] = m_s1[c];
                m_s1[c] = key[c];
                toggled = 1'b0;
                if (prev != m_ks[c]) begin
                    run[c]++;
                    if (run[c] == DC) begin
                        run[c]  = 0;
                        m_ks[c] = prev;
                        toggled = 1'b1;
                        if (prev) begin
                            m_pr[c] = 1'b1;
                            age[c]  = 0;
                        end else begin
                            m_rl[c] = 1'b1;
                        end
                    end
                end else begin
                    run[c] = 0;
                end
                if (!toggled && m_ks[c]) begin
                    age[c]++;
                    if (age[c] == LC) m_lg[c] = 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
                    if (age[c] > LC && ((age[c] - LC) % RC) == 0) m_rp[c] = 1'b1;
`endif
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc_n++;
        chk($sformatf("model@%0d", cyc_n),
            {12'd0, key_state, press_tic, release_tic, long_tic, repeat_tic},
            {12'd0, m_ks, m_pr, m_rl, m_lg, m_rp});
    endtask

    typedef struct {
        logic          rst;
        logic [NK-1:0] key;
        int            hold;
        logic [NK-1:0] ks;
        logic [NK-1:0] pr;
        logic [NK-1:0] rl;
        logic [NK-1:0] lg;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic r, input logic [NK-1:0] k, input int h,
                               input logic [NK-1:0] ks, input logic [NK-1:0] pr,
                               input logic [NK-1:0] rl, input logic [NK-1:0] lg);
        vec_t t;
        t.rst = r; t.key = k; t.hold = h; t.ks = ks; t.pr = pr; t.rl = rl; t.lg = lg;
        return t;
    endfunction

    int hold_left [NK];
    int seen;
    logic exp_l, exp_r;

    initial begin
        // reset and single press on key 0
        tbl.push_back(v(1, 4'b0000, 2,  4'b0000, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0001, 5,  4'b0000, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0001, 1,  4'b0001, 4'b0001, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0001, 1,  4'b0001, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0001, 4,  4'b0001, 4'b0000, 4'b0000, 4'b0000));
        // key 1 bounce 1,0,1,1,0 then a 3-cycle pulse
        tbl.push_back(v(0, 4'b0011, 1,  4'b0001, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0001, 1,  4'b0001, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0011, 2,  4'b0001, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0001, 9,  4'b0001, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0011, 3,  4'b0001, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0001, 6,  4'b0001, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0000, 5,  4'b0001, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0000, 1,  4'b0000, 4'b0000, 4'b0001, 4'b0000));
        // key 2 long press, held 40 cycles past press_tic
        tbl.push_back(v(0, 4'b0100, 5,  4'b0000, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0100, 1,  4'b0100, 4'b0100, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0100, 19, 4'b0100, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0100, 1,  4'b0100, 4'b0000, 4'b0000, 4'b0100));
        tbl.push_back(v(0, 4'b0100, 1,  4'b0100, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0100, 19, 4'b0100, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0000, 5,  4'b0100, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0000, 1,  4'b0000, 4'b0000, 4'b0100, 4'b0000));
        tbl.push_back(v(0, 4'b0000, 2,  4'b0000, 4'b0000, 4'b0000, 4'b0000));
        // all keys together; release lands on the long_tic edge
        tbl.push_back(v(0, 4'b1111, 5,  4'b0000, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b1111, 1,  4'b1111, 4'b1111, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b1111, 14, 4'b1111, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0000, 5,  4'b1111, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0000, 1,  4'b0000, 4'b0000, 4'b1111, 4'b0000));
        tbl.push_back(v(0, 4'b0000, 2,  4'b0000, 4'b0000, 4'b0000, 4'b0000));
        // reset mid-debounce, fresh press, reset mid-S_LONG
        tbl.push_back(v(0, 4'b0001, 3,  4'b0000, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(v(1, 4'b0001, 1,  4'b0000, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0001, 5,  4'b0000, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0001, 1,  4'b0001, 4'b0001, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0001, 24, 4'b0001, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(v(1, 4'b0001, 1,  4'b0000, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0000, 8,  4'b0000, 4'b0000, 4'b0000, 4'b0000));

        for (int c = 0; c < NK; c++) begin
            run[c] = 0;
            age[c] = 0;
        end

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst;
            key = tbl[i].key;
            repeat (tbl[i].hold) cyc();
            chk($sformatf("tbl[%0d].key_state", i),   {28'd0, key_state},   {28'd0, tbl[i].ks});
            chk($sformatf("tbl[%0d].press_tic", i),   {28'd0, press_tic},   {28'd0, tbl[i].pr});
            chk($sformatf("tbl[%0d].release_tic", i), {28'd0, release_tic}, {28'd0, tbl[i].rl});
            chk($sformatf("tbl[%0d].long_tic", i),    {28'd0, long_tic},    {28'd0, tbl[i].lg});
        end

        // key 3 held: repeat tics 8/16/24 cycles after long_tic only with auto-repeat
        rst = 1'b0;
        key = 4'b1000;
        seen = 0;
        for (int n = 0; n < 20 && seen == 0; n++) begin
            cyc();
            if (press_tic[3]) seen = 1;
        end
        chk("press3_wait", seen, 1);
        for (int k = 1; k <= 44; k++) begin
            cyc();
            exp_l = (k == LC);
`ifdef KEY_AUTO_REPEAT_EN
            exp_r = (k > LC) && (((k - LC) % RC) == 0);
`else
            exp_r = 1'b0;
`endif
            chk($sformatf("long3_k%0d", k), {31'd0, long_tic[3]}, {31'd0, exp_l});
            chk($sformatf("repeat3_k%0d", k), {31'd0, repeat_tic[3]}, {31'd0, exp_r});
        end
        key = 4'b0000;
        for (int k = 0; k < 12; k++) begin
            cyc();
            chk($sformatf("repeat3_rel%0d", k), {31'd0, repeat_tic[3]}, 32'd0);
        end

        // random run: mixed glitches and long holds per channel, occasional reset
        for (int c = 0; c < NK; c++) hold_left[c] = $urandom_range(1, 40);
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 399) == 0);
            for (int c = 0; c < NK; c++) begin
                hold_left[c]--;
                if (hold_left[c] <= 0) begin
                    key[c] = ~key[c];
                    hold_left[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                                : $urandom_range(5, 60);
                end
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
